rc4_prga_engine: RTL



---
 rtl/rc4_prga_engine.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/rc4_prga_engine.sv
// rc4_prga_engine: RC4 keystream generator / decryptor (PRGA phase).
// Runs after the KSA has filled the S RAM. Each message byte costs seven
// cycles: read S[i], update j and read S[j], swap S[i] and S[j], read
// S[S[i]+S[j]] together with the ciphertext byte, then write the plaintext.
// An optional plausibility check aborts on the first out-of-range byte.
// All three RAMs return read data one cycle after the address is presented.
//
// Optional feature macro: RC4_DROP_EN
//   When defined, a 16-bit drop_n input is sampled at start acceptance and
//   that many keystream rounds (5 cycles each, no message access) are
//   discarded before byte 0 (RC4-drop[n]).
//
// Control protocol: start is a level request. It is accepted on a rising
// clock edge only while the engine is in IDLE or DONE (busy=0); msg_len,
// check_en (and drop_n) are captured on that same edge. While busy=1 start
// is ignored. done stays high, and pass/fail_idx stay stable, until the
// next accepted start.
module rc4_prga_engine #(
    parameter int STATE_W  = 8,
    parameter int MSG_AW   = 5,
    parameter int CHAR_LO  = 97,
    parameter int CHAR_HI  = 122,
    parameter int CHAR_ALT = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MSG_AW:0]    msg_len,
    input  logic               check_en,
`ifdef RC4_DROP_EN
    input  logic [15:0]        drop_n,
`endif
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [MSG_AW-1:0]  fail_idx,
    output logic [STATE_W-1:0] s_addr,
    output logic [STATE_W-1:0] s_wdata,
    output logic               s_wren,
    input  logic [STATE_W-1:0] s_rdata,
    output logic [MSG_AW-1:0]  m_addr,
    input  logic [7:0]         m_rdata,
    output logic [MSG_AW-1:0]  a_addr,
    output logic [7:0]         a_wdata,
    output logic               a_wren,
    output logic [3:0]         dbg_state
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RD_I  = 4'd1,
        ST_CAP_I = 4'd2,
        ST_CAP_J = 4'd3,
        ST_WR_I  = 4'd4,
        ST_WR_J  = 4'd5,
        ST_RD_K  = 4'd6,
        ST_CAP_K = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

    // Keystream bytes wider or narrower than 8 bits are folded onto the
    // 8-bit message path through a zero-extended intermediate.
    localparam int PW = (STATE_W > 8) ? STATE_W : 8;

    localparam logic [7:0]      LO8     = 8'(CHAR_LO);
    localparam logic [7:0]      HI8     = 8'(CHAR_HI);
    localparam logic [7:0]      ALT8    = 8'(CHAR_ALT);
    localparam logic [MSG_AW:0] LEN_ONE = (MSG_AW + 1)'(1);

    state_t              r_state;
    state_t              w_next;

    logic [STATE_W-1:0]  r_i;
    logic [STATE_W-1:0]  r_j;
    logic [STATE_W-1:0]  r_si;
    logic [STATE_W-1:0]  r_sj;
    logic [MSG_AW-1:0]   r_k;
    logic [MSG_AW:0]     r_len;
    logic                r_chk;
    logic                r_pass;
    logic [MSG_AW-1:0]   r_fail_idx;

    logic                w_start_acc;
    logic                w_zero_work;
    logic                w_byte_fail;
    logic                w_last_byte;
    logic                w_legal;
    logic [PW-1:0]       w_ks_ext;
    logic [7:0]          w_p;
    logic                w_drop_active;
    logic                w_drop_last;

`ifdef RC4_DROP_EN
    logic [15:0]         r_drop_left;

    assign w_zero_work   = (msg_len == '0) && (drop_n == 16'd0);
    assign w_drop_active = (r_drop_left != 16'd0);
    assign w_drop_last   = (r_drop_left == 16'd1);
`else
    assign w_zero_work   = (msg_len == '0);
    assign w_drop_active = 1'b0;
    assign w_drop_last   = 1'b0;
`endif

    // Plaintext byte formed in CAP_K and its legality under the check.
    assign w_ks_ext    = PW'(s_rdata);
    assign w_p         = w_ks_ext[7:0] ^ m_rdata;
    assign w_legal     = ((w_p >= LO8) && (w_p <= HI8)) || (w_p == ALT8);
    assign w_last_byte = ({1'b0, r_k} == (r_len - LEN_ONE));

    assign pass      = r_pass;
    assign fail_idx  = r_fail_idx;
    assign dbg_state = r_state;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and all RAM-side outputs; everything idles at 0.
    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        w_byte_fail = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wren      = 1'b0;
        m_addr      = '0;
        a_addr      = '0;
        a_wdata     = '0;
        a_wren      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                done = (r_state == ST_DONE);
                if (start) begin
                    w_start_acc = 1'b1;
                    w_next      = w_zero_work ? ST_DONE : ST_RD_I;
                end
            end
            ST_RD_I: begin
                busy   = 1'b1;
                s_addr = r_i;
                w_next = ST_CAP_I;
            end
            ST_CAP_I: begin
                busy   = 1'b1;
                s_addr = r_j + s_rdata;
                w_next = ST_CAP_J;
            end
            ST_CAP_J: begin
                busy   = 1'b1;
                w_next = ST_WR_I;
            end
            ST_WR_I: begin
                busy    = 1'b1;
                s_addr  = r_i;
                s_wdata = r_sj;
                s_wren  = 1'b1;
                w_next  = ST_WR_J;
            end
            ST_WR_J: begin
                busy    = 1'b1;
                s_addr  = r_j;
                s_wdata = r_si;
                s_wren  = 1'b1;
                if (w_drop_active) begin
                    // Discard round: skip the message, maybe finish outright.
                    w_next = (w_drop_last && (r_len == '0)) ? ST_DONE : ST_RD_I;
                end else begin
                    w_next = ST_RD_K;
                end
            end
            ST_RD_K: begin
                busy   = 1'b1;
                s_addr = r_si + r_sj;
                m_addr = r_k;
                w_next = ST_CAP_K;
            end
            ST_CAP_K: begin
                busy        = 1'b1;
                a_addr      = r_k;
                a_wdata     = w_p;
                w_byte_fail = r_chk && !w_legal;
                a_wren      = !w_byte_fail;
                w_next      = (w_byte_fail || w_last_byte) ? ST_DONE : ST_RD_I;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: indices, captured S values, run parameters and the verdict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i        <= '0;
            r_j        <= '0;
            r_si       <= '0;
            r_sj       <= '0;
            r_k        <= '0;
            r_len      <= '0;
            r_chk      <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_idx <= '0;
        end else if (w_start_acc) begin
            // i is pre-incremented on every entry into RD_I.
            r_i        <= (w_next == ST_RD_I) ? STATE_W'(1) : '0;
            r_j        <= '0;
            r_k        <= '0;
            r_len      <= msg_len;
            r_chk      <= check_en;
            r_pass     <= 1'b1;
            r_fail_idx <= '0;
        end else begin
            case (r_state)
                ST_CAP_I: begin
                    r_si <= s_rdata;
                    r_j  <= r_j + s_rdata;
                end
                ST_CAP_J: begin
                    r_sj <= s_rdata;
                end
                ST_WR_J: begin
                    if (w_next == ST_RD_I) begin
                        r_i <= r_i + STATE_W'(1);
                    end
                end
                ST_CAP_K: begin
                    if (w_byte_fail) begin
                        r_pass     <= 1'b0;
                        r_fail_idx <= r_k;
                    end else if (!w_last_byte) begin
                        r_k <= r_k + MSG_AW'(1);
                        r_i <= r_i + STATE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RC4_DROP_EN
    // Remaining discard rounds; one is consumed at the end of each WR_J.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_left <= 16'd0;
        end else if (w_start_acc) begin
            r_drop_left <= drop_n;
        end else if ((r_state == ST_WR_J) && w_drop_active) begin
            r_drop_left <= r_drop_left - 16'd1;
        end
    end
`endif

endmodule
